// File: rtl/ea_gen_pkg.sv
// ea_gen_pkg: shared types and constants for the effective-address generator.
//  state_t      - control FSM states
//  ADDR2_*      - offset field select encodings (addr2_sel)
//  IR*_MSB      - MSB position of each IR offset field
package ea_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam logic [1:0] ADDR2_IR11 = 2'b00;
  localparam logic [1:0] ADDR2_IR9  = 2'b01;
  localparam logic [1:0] ADDR2_IR6  = 2'b10;
  localparam logic [1:0] ADDR2_ZERO = 2'b11;

  localparam int unsigned IR_W     = 16;
  localparam int unsigned IR11_MSB = 10;
  localparam int unsigned IR9_MSB  = 8;
  localparam int unsigned IR6_MSB  = 5;

endpackage

// File: rtl/ea_offset_sel.sv
// ea_offset_sel: selects an IR offset field, sign-extends it to DATA_W and
// applies the SCALE_SH left shift.
//  ir            in   instruction word
//  addr2_sel     in   offset field select (ADDR2_*)
//  offset_c      out  sign-extended, shifted offset
//  offset_sign_c out  sign of the selected field (0 for the zero select)
module ea_offset_sel
  import ea_gen_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned SCALE_SH = 0
) (
  input  logic [IR_W-1:0]   ir,
  input  logic [1:0]        addr2_sel,
  output logic [DATA_W-1:0] offset_c,
  output logic              offset_sign_c
);

  logic [DATA_W-1:0] sext;

  // Bits above the widest offset field carry opcode/register info only.
  logic unused_ir_hi;
  assign unused_ir_hi = ^ir[IR_W-1:IR11_MSB+1];

  // Field select with sign extension.
  always_comb begin
    sext          = '0;
    offset_sign_c = 1'b0;
    case (addr2_sel)
      ADDR2_IR11: begin
        offset_sign_c = ir[IR11_MSB];
        sext          = {{(DATA_W-IR11_MSB-1){ir[IR11_MSB]}}, ir[IR11_MSB:0]};
      end
      ADDR2_IR9: begin
        offset_sign_c = ir[IR9_MSB];
        sext          = {{(DATA_W-IR9_MSB-1){ir[IR9_MSB]}}, ir[IR9_MSB:0]};
      end
      ADDR2_IR6: begin
        offset_sign_c = ir[IR6_MSB];
        sext          = {{(DATA_W-IR6_MSB-1){ir[IR6_MSB]}}, ir[IR6_MSB:0]};
      end
      default: begin
        offset_sign_c = 1'b0;
        sext          = '0;
      end
    endcase
  end

  assign offset_c = sext << SCALE_SH;

endmodule

// File: rtl/ea_gen_pipe.sv
// ea_gen_pipe: effective-address generator with registered, handshaked output
// and optional pointer indirection (LDI/STI).
//  Clk, Reset_n          clock, async active-low reset
//  flush                 synchronous abort of the current op
//  in_valid/in_ready     request handshake; ir/pc/sr1/addr1_sel/addr2_sel/indirect operands
//  mem_req_*             pointer read request (address = computed EA)
//  mem_rsp_*             pointer read data
//  out_valid/out_ready   result handshake; out_addr final address, out_wrap EA-add wrap flag
module ea_gen_pipe
  import ea_gen_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned SCALE_SH = 0
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IR_W-1:0]   ir,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] sr1,
  input  logic              addr1_sel,
  input  logic [1:0]        addr2_sel,
  input  logic              indirect,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [DATA_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_addr,
  output logic              out_wrap
);

  state_t            state;
  logic [DATA_W-1:0] ea_q;
  logic              wrap_q;
  logic              drop_q;

  logic [DATA_W-1:0] base_c;
  logic [DATA_W-1:0] offset_c;
  logic              offset_sign_c;
  logic [DATA_W:0]   sum_c;
  logic              wrap_c;
  logic              drop_set_c;

  ea_offset_sel #(
    .DATA_W   (DATA_W),
    .SCALE_SH (SCALE_SH)
  ) u_offset_sel (
    .ir            (ir),
    .addr2_sel     (addr2_sel),
    .offset_c      (offset_c),
    .offset_sign_c (offset_sign_c)
  );

  // Adder: carry out XOR offset sign flags a crossing of 0 / 2^DATA_W-1.
  assign base_c = addr1_sel ? sr1 : pc;
  assign sum_c  = {1'b0, base_c} + {1'b0, offset_c};
  assign wrap_c = sum_c[DATA_W] ^ offset_sign_c;

  // A flush that leaves a pointer read in flight must swallow its response.
  assign drop_set_c = (state == WAIT) || ((state == REQ) && mem_req_ready);

  assign mem_req_addr = ea_q;
  assign out_addr     = ea_q;
  assign out_wrap     = wrap_q;

  // Control FSM with registered handshake outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state         <= IDLE;
      ea_q          <= '0;
      wrap_q        <= 1'b0;
      drop_q        <= 1'b0;
      in_ready      <= 1'b1;
      mem_req_valid <= 1'b0;
      out_valid     <= 1'b0;
    end else if (flush) begin
      state         <= IDLE;
      mem_req_valid <= 1'b0;
      out_valid     <= 1'b0;
      if (drop_set_c) begin
        drop_q   <= 1'b1;
        in_ready <= 1'b0;
      end else if (drop_q && mem_rsp_valid) begin
        drop_q   <= 1'b0;
        in_ready <= 1'b1;
      end else begin
        in_ready <= !drop_q;
      end
    end else begin
      case (state)
        IDLE: begin
          if (drop_q) begin
            if (mem_rsp_valid) begin
              drop_q   <= 1'b0;
              in_ready <= 1'b1;
            end
          end else if (in_valid && in_ready) begin
            ea_q     <= sum_c[DATA_W-1:0];
            wrap_q   <= wrap_c;
            in_ready <= 1'b0;
            if (indirect) begin
              state         <= REQ;
              mem_req_valid <= 1'b1;
            end else begin
              state     <= OUT;
              out_valid <= 1'b1;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            state         <= WAIT;
            mem_req_valid <= 1'b0;
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            ea_q      <= mem_rsp_data;
            state     <= OUT;
            out_valid <= 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
